// File: rtl/inv_lifting_unit_1d.sv
// ---------------------------------------------------------------------------
// inv_lifting_unit_1d
//
// Undoes one predict/update lifting pair of the 9/7 wavelet along a row.
// Coefficient pairs {d, s} are turned back into sample pairs {x_odd, x_even}:
//   x_even[n] = s[n] - Beta  * (d[n-1] + d[n])
//   x_odd[n]  = d[n] - Alpha * (x_even[n] + x_even[n+1])
// Line edges use symmetric extension (d[-1] = d[0], x_even[N] = x_even[N-1]).
// Two instances with swapped coefficients make up the inverse 1D transform.
//
// Pipeline: input skid buffer -> stage E (x_even) -> stage O (pending pair,
// x_odd) -> output register.
//
// Ports
//   clk_i      clock
//   rst_ni     asynchronous reset, active low
//   s_ready_o  input ready (registered)
//   s_valid_i  input valid
//   s_sof_i    first pair of frame
//   s_eol_i    last pair of line
//   s_data_i   {d, s}
//   m_ready_i  output ready
//   m_valid_o  output valid
//   m_sof_o    first output pair of frame
//   m_eol_o    last output pair of line
//   m_data_o   {x_odd, x_even}
// ---------------------------------------------------------------------------
module inv_lifting_unit_1d #(
  parameter int  DataWidth = 16,
  parameter int  Point     = 10,
  parameter real Alpha     = 0.5,
  parameter real Beta      = 0.25
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output logic                   s_ready_o,
  input  logic                   s_valid_i,
  input  logic                   s_sof_i,
  input  logic                   s_eol_i,
  input  logic [2*DataWidth-1:0] s_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o
);

  localparam int KaInt = $rtoi(Alpha * (2.0 ** Point));
  localparam int KbInt = $rtoi(Beta * (2.0 ** Point));
  localparam logic signed [2*DataWidth-1:0] KaWide = (2*DataWidth)'(KaInt);
  localparam logic signed [2*DataWidth-1:0] KbWide = (2*DataWidth)'(KbInt);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPend  = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  // Input skid buffer
  logic                   r_ready;
  logic                   r_aValid, r_aSof, r_aEol;
  logic [2*DataWidth-1:0] r_aData;
  logic                   r_skValid, r_skSof, r_skEol;
  logic [2*DataWidth-1:0] r_skData;

  // Stage E
  logic                   r_eValid, r_eSof, r_eEol;
  logic [DataWidth-1:0]   r_eXe, r_eD;
  logic [DataWidth-1:0]   r_dPrev;
  logic                   r_first;

  // Stage O
  logic [1:0]             r_state;
  logic [DataWidth-1:0]   r_pXe, r_pD;
  logic                   r_pSof;
  logic                   r_mValid, r_mSof, r_mEol;
  logic [2*DataWidth-1:0] r_mData;

  logic                   w_accept, w_aPop, w_oTake, w_outFree, w_emit, w_lineEnd;
  logic [DataWidth-1:0]   w_aD, w_aS, w_dLeft, w_sumD, w_xe;
  logic [DataWidth-1:0]   w_xeRight, w_sumX, w_xo;
  logic signed [2*DataWidth-1:0] w_sumDExt, w_sumXExt, w_prodE, w_prodO;
  logic                   w_unusedBits;

  assign s_ready_o = r_ready;
  assign m_valid_o = r_mValid;
  assign m_sof_o   = r_mSof;
  assign m_eol_o   = r_mEol;
  assign m_data_o  = r_mData;

  assign w_accept  = s_valid_i & r_ready;
  assign w_outFree = ~r_mValid | m_ready_i;
  assign w_oTake   = r_eValid & ((r_state == StIdle) | ((r_state == StPend) & w_outFree));
  assign w_aPop    = r_aValid & (~r_eValid | w_oTake);

  // Ready only depends on whether the skid slot is occupied, so m_ready_i
  // never reaches s_ready_o combinationally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ready   <= 1'b0;
      r_aValid  <= 1'b0;
      r_aSof    <= 1'b0;
      r_aEol    <= 1'b0;
      r_aData   <= '0;
      r_skValid <= 1'b0;
      r_skSof   <= 1'b0;
      r_skEol   <= 1'b0;
      r_skData  <= '0;
    end else if (r_skValid) begin
      r_ready <= w_aPop;
      if (w_aPop) begin
        r_aData   <= r_skData;
        r_aSof    <= r_skSof;
        r_aEol    <= r_skEol;
        r_skValid <= 1'b0;
      end
    end else begin
      r_ready <= ~(w_accept & r_aValid & ~w_aPop);
      if (w_accept) begin
        if (!r_aValid || w_aPop) begin
          r_aValid <= 1'b1;
          r_aData  <= s_data_i;
          r_aSof   <= s_sof_i;
          r_aEol   <= s_eol_i;
        end else begin
          r_skValid <= 1'b1;
          r_skData  <= s_data_i;
          r_skSof   <= s_sof_i;
          r_skEol   <= s_eol_i;
        end
      end else if (w_aPop) begin
        r_aValid <= 1'b0;
      end
    end
  end

  // Stage E: the first pair of a line mirrors its own d as the left neighbour.
  assign w_aD      = r_aData[2*DataWidth-1:DataWidth];
  assign w_aS      = r_aData[DataWidth-1:0];
  assign w_dLeft   = (r_first | r_aSof) ? w_aD : r_dPrev;
  assign w_sumD    = w_dLeft + w_aD;
  assign w_sumDExt = {{DataWidth{w_sumD[DataWidth-1]}}, w_sumD};
  assign w_prodE   = KbWide * w_sumDExt;
  assign w_xe      = w_aS - w_prodE[Point +: DataWidth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_eValid <= 1'b0;
      r_eSof   <= 1'b0;
      r_eEol   <= 1'b0;
      r_eXe    <= '0;
      r_eD     <= '0;
      r_dPrev  <= '0;
      r_first  <= 1'b1;
    end else if (w_aPop) begin
      r_eValid <= 1'b1;
      r_eSof   <= r_aSof;
      r_eEol   <= r_aEol;
      r_eXe    <= w_xe;
      r_eD     <= w_aD;
      r_dPrev  <= w_aD;
      r_first  <= r_aEol;
    end else if (w_oTake) begin
      r_eValid <= 1'b0;
    end
  end

  // Stage O: the pending pair closes its line either in FLUSH or when a sof
  // pair shows up without a preceding eol; both mirror x_even on the right.
  assign w_lineEnd = (r_state == StFlush) | r_eSof;
  assign w_emit    = w_outFree & (((r_state == StPend) & r_eValid) | (r_state == StFlush));
  assign w_xeRight = w_lineEnd ? r_pXe : r_eXe;
  assign w_sumX    = r_pXe + w_xeRight;
  assign w_sumXExt = {{DataWidth{w_sumX[DataWidth-1]}}, w_sumX};
  assign w_prodO   = KaWide * w_sumXExt;
  assign w_xo      = r_pD - w_prodO[Point +: DataWidth];

  assign w_unusedBits = ^{w_prodE[Point-1:0], w_prodE[2*DataWidth-1:Point+DataWidth],
                          w_prodO[Point-1:0], w_prodO[2*DataWidth-1:Point+DataWidth]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_pXe   <= '0;
      r_pD    <= '0;
      r_pSof  <= 1'b0;
    end else if (w_oTake) begin
      r_pXe   <= r_eXe;
      r_pD    <= r_eD;
      r_pSof  <= r_eSof;
      r_state <= r_eEol ? StFlush : StPend;
    end else if ((r_state == StFlush) && w_outFree) begin
      r_state <= StIdle;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mValid <= 1'b0;
      r_mSof   <= 1'b0;
      r_mEol   <= 1'b0;
      r_mData  <= '0;
    end else if (w_outFree) begin
      r_mValid <= w_emit;
      if (w_emit) begin
        r_mData <= {w_xo, r_pXe};
        r_mSof  <= r_pSof;
        r_mEol  <= w_lineEnd;
      end
    end
  end

endmodule

// File: tb/tb_inv_lifting_unit_1d.sv
// ---------------------------------------------------------------------------
// tb_inv_lifting_unit_1d
//
// Drives lines of {d, s} pairs into inv_lifting_unit_1d and compares every
// output beat against a line-level arithmetic model of the inverse lifting
// step (Alpha=0.5, Beta=0.25, 16-bit samples, 10 fractional bits).
// ---------------------------------------------------------------------------
module tb_inv_lifting_unit_1d;

  localparam int KA = 512;
  localparam int KB = 256;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        s_ready_o;
  logic        s_valid_i;
  logic        s_sof_i;
  logic        s_eol_i;
  logic [31:0] s_data_i;
  logic        m_ready_i;
  logic        m_valid_o;
  logic        m_sof_o;
  logic        m_eol_o;
  logic [31:0] m_data_o;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [33:0] expQ[$];
  int          readyMode  = 0;
  logic        readyPhase = 1'b0;
  logic        gapEnable  = 1'b0;
  logic [15:0] lineD[64];
  logic [15:0] lineS[64];

  always #5 clk_i = ~clk_i;

  inv_lifting_unit_1d #(
    .DataWidth(16),
    .Point(10),
    .Alpha(0.5),
    .Beta(0.25)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .s_ready_o(s_ready_o),
    .s_valid_i(s_valid_i),
    .s_sof_i(s_sof_i),
    .s_eol_i(s_eol_i),
    .s_data_i(s_data_i),
    .m_ready_i(m_ready_i),
    .m_valid_o(m_valid_o),
    .m_sof_o(m_sof_o),
    .m_eol_o(m_eol_o),
    .m_data_o(m_data_o)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  // Fixed-point coefficient times a 16-bit signed value, floor-shifted back.
  function automatic logic [15:0] mulShift(input int k, input logic [15:0] v);
    longint p;
    p = longint'(k) * longint'($signed(v));
    return 16'(p >>> 10);
  endfunction

  // Queue the expected beats of one whole line held in lineD/lineS.
  task automatic pushLine(input int n, input logic sofFirst);
    logic [15:0] xe[65];
    logic [15:0] dl, xr, sum, xo;
    for (int i = 0; i < n; i++) begin
      dl = (i == 0) ? lineD[0] : lineD[i-1];
      sum = dl + lineD[i];
      xe[i] = lineS[i] - mulShift(KB, sum);
    end
    for (int i = 0; i < n; i++) begin
      xr = (i == n - 1) ? xe[i] : xe[i+1];
      sum = xe[i] + xr;
      xo = lineD[i] - mulShift(KA, sum);
      expQ.push_back({(sofFirst && (i == 0)), (i == n - 1), xo, xe[i]});
    end
  endtask

  task automatic randomLine(input int n);
    for (int i = 0; i < n; i++) begin
      lineD[i] = 16'($urandom);
      lineS[i] = 16'($urandom);
    end
  endtask

  // Called right after a negedge; returns right after the negedge following the transfer.
  task automatic applyStimulus(input logic [15:0] d, input logic [15:0] s, input logic sof, input logic eol);
    int waited;
    if (gapEnable) begin
      repeat ($urandom_range(0, 2)) begin
        s_valid_i = 1'b0;
        s_sof_i   = 1'($urandom);
        s_eol_i   = 1'($urandom);
        s_data_i  = $urandom;
        @(negedge clk_i);
      end
    end
    s_valid_i = 1'b1;
    s_data_i  = {d, s};
    s_sof_i   = sof;
    s_eol_i   = eol;
    waited = 0;
    while (!s_ready_o && waited < 1000) begin
      @(negedge clk_i);
      waited++;
    end
    checkOutput("accept", 64'(s_ready_o), 64'd1);
    @(negedge clk_i);
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
    s_eol_i   = 1'b0;
  endtask

  task automatic driveLine(input int n, input logic sofFirst, input logic withEol);
    for (int i = 0; i < n; i++)
      applyStimulus(lineD[i], lineS[i], sofFirst && (i == 0), withEol && (i == n - 1));
  endtask

  task automatic drainWait();
    int c;
    c = 0;
    while (expQ.size() != 0 && c < 5000) begin
      @(negedge clk_i);
      c++;
    end
    repeat (8) @(negedge clk_i);
    checkOutput("drain", 64'(expQ.size()), 64'd0);
  endtask

  // Output side: choose m_ready_i for the coming edge, then check what is shown.
  initial begin
    logic [33:0] obs;
    m_ready_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        case (readyMode)
          0:       m_ready_i = 1'b1;
          1:       m_ready_i = ($urandom_range(0, 3) != 0);
          default: begin
            readyPhase = ~readyPhase;
            m_ready_i  = readyPhase;
          end
        endcase
        obs = {m_sof_o, m_eol_o, m_data_o};
        if (m_valid_o) begin
          if (expQ.size() == 0) checkOutput("extraBeat", 64'(expQ.size()), 64'd1);
          else if (m_ready_i) checkOutput("beat", 64'(obs), 64'(expQ.pop_front()));
          else checkOutput("hold", 64'(obs), 64'(expQ[0]));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d/%0d", passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_ni    = 1'b1;
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
    s_eol_i   = 1'b0;
    s_data_i  = '0;
    #1 rst_ni = 1'b0;
    #2;
    checkOutput("rstValid", 64'(m_valid_o), 64'd0);
    checkOutput("rstSof",   64'(m_sof_o),   64'd0);
    checkOutput("rstEol",   64'(m_eol_o),   64'd0);
    checkOutput("rstData",  64'(m_data_o),  64'd0);
    checkOutput("rstReady", 64'(s_ready_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("readyAfterRelease", 64'(s_ready_o), 64'd1);

    // Single-pair line with known result
    expQ.push_back({1'b1, 1'b1, 32'hFE00_0600});
    applyStimulus(16'h0400, 16'h0800, 1'b1, 1'b1);
    drainWait();

    // Four zero pairs
    expQ.push_back({1'b1, 1'b0, 32'h0});
    expQ.push_back({1'b0, 1'b0, 32'h0});
    expQ.push_back({1'b0, 1'b0, 32'h0});
    expQ.push_back({1'b0, 1'b1, 32'h0});
    for (int i = 0; i < 4; i++) applyStimulus(16'h0, 16'h0, (i == 0), (i == 3));
    drainWait();

    // Line of 3 without eol, closed by a new sof line
    randomLine(3);
    pushLine(3, 1'b1);
    driveLine(3, 1'b1, 1'b0);
    randomLine(2);
    pushLine(2, 1'b1);
    driveLine(2, 1'b1, 1'b1);
    drainWait();

    // 16-pair line under alternating output ready
    readyMode = 2;
    randomLine(16);
    pushLine(16, 1'b1);
    driveLine(16, 1'b1, 1'b1);
    drainWait();
    readyMode = 0;

    // Reset in the middle of a line, then a fresh line
    randomLine(8);
    pushLine(8, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(lineD[i], lineS[i], (i == 0), 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("midRstValid", 64'(m_valid_o), 64'd0);
    checkOutput("midRstReady", 64'(s_ready_o), 64'd0);
    checkOutput("midRstData",  64'({m_sof_o, m_eol_o, m_data_o}), 64'd0);
    expQ.delete();
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    randomLine(5);
    pushLine(5, 1'b1);
    driveLine(5, 1'b1, 1'b1);
    drainWait();

    // Random lines with random input gaps and output stalls
    readyMode = 1;
    gapEnable = 1'b1;
    for (int l = 0; l < 200; l++) begin
      int n;
      logic sof;
      n = $urandom_range(1, 64);
      sof = (l == 0) || ($urandom_range(0, 3) == 0);
      randomLine(n);
      pushLine(n, sof);
      driveLine(n, sof, 1'b1);
    end
    drainWait();

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
